// File: rtl/uart_bus_master.sv
// Bus initiator that turns host commands into UART register-bus read/write cycles.
// Optional interrupt-acknowledge/vector-fetch sequence is built when UART_INT_ACK_EN is defined.
module uart_bus_master #(
  parameter logic [2:0] ISR_ADDR   = 3'd5,
  parameter logic [2:0] LDVR_ADDR  = 3'd1,
  parameter logic [2:0] UDVR_ADDR  = 3'd2,
  parameter logic [7:0] ISR_VECTOR = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic        cmd_wide_i,
  input  logic [2:0]  cmd_address_i,
  input  logic [15:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic        read_o,
  output logic        write_o,
  output logic [2:0]  address_o,
  output logic [7:0]  data_o,
  output logic        data_oe_o,
  input  logic [7:0]  data_i,
  input  logic        int_req_i,
  output logic        int_ackn_o,
  output logic        int_vector_valid_o,
  output logic [2:0]  int_vector_o,
  output logic        int_spurious_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_HI   = 3'd2,
    S_RD      = 3'd3,
    S_RSP     = 3'd4
`ifdef UART_INT_ACK_EN
    ,
    S_ACK     = 3'd5,
    S_ACK_ISR = 3'd6
`endif
  } state_t;

  state_t     r_state;
  logic       r_read;
  logic       r_write;
  logic       r_oe;
  logic [2:0] r_address;
  logic [7:0] r_data;
  logic [7:0] r_wdata_hi;
  logic       r_wide;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       w_int_start;

`ifdef UART_INT_ACK_EN
  logic       r_ackn;
  logic       r_vec_valid;
  logic [2:0] r_vector;
  logic       r_spurious;

  assign w_int_start = (r_state == S_IDLE) && int_req_i;
`else
  logic w_unused;

  // Without the acknowledge feature these inputs/parameters have no consumer.
  assign w_unused    = ^{int_req_i, ISR_ADDR, ISR_VECTOR};
  assign w_int_start = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_oe        <= 1'b0;
      r_address   <= 3'd0;
      r_data      <= 8'd0;
      r_wdata_hi  <= 8'd0;
      r_wide      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'd0;
`ifdef UART_INT_ACK_EN
      r_ackn      <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vector    <= 3'd0;
      r_spurious  <= 1'b0;
`endif
    end else begin
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_oe        <= 1'b0;
      r_rsp_valid <= 1'b0;
`ifdef UART_INT_ACK_EN
      r_ackn      <= 1'b0;
      r_vec_valid <= 1'b0;
      r_spurious  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
`ifdef UART_INT_ACK_EN
          if (w_int_start) begin
            r_state <= S_ACK;
            r_read  <= 1'b1;
            r_ackn  <= 1'b1;
          end else
`endif
          if (cmd_valid_i) begin
            r_address <= cmd_address_i;
            if (cmd_write_i) begin
              r_state    <= S_WR;
              r_write    <= 1'b1;
              r_oe       <= 1'b1;
              r_data     <= cmd_wdata_i[7:0];
              r_wdata_hi <= cmd_wdata_i[15:8];
              r_wide     <= cmd_wide_i && (cmd_address_i == LDVR_ADDR);
            end else begin
              r_state <= S_RD;
              r_read  <= 1'b1;
            end
          end
        end
        S_WR: begin
          // Upper divisor byte follows immediately so the divisor never sits half-written.
          if (r_wide) begin
            r_state   <= S_WR_HI;
            r_write   <= 1'b1;
            r_oe      <= 1'b1;
            r_address <= UDVR_ADDR;
            r_data    <= r_wdata_hi;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WR_HI: r_state <= S_IDLE;
        S_RD: begin
          r_rsp_data  <= data_i;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RSP: r_state <= S_IDLE;
`ifdef UART_INT_ACK_EN
        S_ACK: begin
          if (data_i == ISR_VECTOR) begin
            r_state   <= S_ACK_ISR;
            r_read    <= 1'b1;
            r_address <= ISR_ADDR;
          end else begin
            r_spurious <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        S_ACK_ISR: begin
          r_vector    <= data_i[2:0];
          r_vec_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (r_state == S_IDLE) && !rst_i && !w_int_start;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign read_o      = r_read;
  assign write_o     = r_write;
  assign address_o   = r_address;
  assign data_o      = r_data;
  assign data_oe_o   = r_oe;

`ifdef UART_INT_ACK_EN
  assign int_ackn_o         = r_ackn;
  assign int_vector_valid_o = r_vec_valid;
  assign int_vector_o       = r_vector;
  assign int_spurious_o     = r_spurious;
`else
  assign int_ackn_o         = 1'b0;
  assign int_vector_valid_o = 1'b0;
  assign int_vector_o       = 3'd0;
  assign int_spurious_o     = 1'b0;
`endif

endmodule
